// File: rtl/pcm_capture_pkg.sv
// Shared audio definitions for the PCM capture and playback paths:
// FSM encoding, frame sizes, rate limit, mono mix and volume curve.
package pcm_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_L_LO,
        ST_WR_L_HI,
        ST_WR_R_LO,
        ST_WR_R_HI
    } pcm_state_e;

    localparam logic [2:0] FRAME_MONO8    = 3'd1;
    localparam logic [2:0] FRAME_STEREO8  = 3'd2;
    localparam logic [2:0] FRAME_MONO16   = 3'd2;
    localparam logic [2:0] FRAME_STEREO16 = 3'd4;

    localparam logic [7:0] MAX_RATE = 8'd128;

    // 17-bit signed sum then arithmetic shift right by one.
    function automatic logic [15:0] mono_mix(input logic [15:0] l, input logic [15:0] r);
        logic [16:0] sum;
        sum = {l[15], l} + {r[15], r};
        return sum[16:1];
    endfunction

    function automatic logic [2:0] frame_bytes(input logic stereo, input logic b16);
        case ({stereo, b16})
            2'b00:   return FRAME_MONO8;
            2'b01:   return FRAME_MONO16;
            2'b10:   return FRAME_STEREO8;
            default: return FRAME_STEREO16;
        endcase
    endfunction

    // Roughly -3 dB per attenuation step; full scale is 255.
    function automatic logic [7:0] vol_gain(input logic [3:0] atten);
        case (atten)
            4'd0:    return 8'd255;
            4'd1:    return 8'd180;
            4'd2:    return 8'd128;
            4'd3:    return 8'd90;
            4'd4:    return 8'd64;
            4'd5:    return 8'd45;
            4'd6:    return 8'd32;
            4'd7:    return 8'd23;
            4'd8:    return 8'd16;
            4'd9:    return 8'd11;
            4'd10:   return 8'd8;
            4'd11:   return 8'd6;
            4'd12:   return 8'd4;
            4'd13:   return 8'd3;
            4'd14:   return 8'd2;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/pcm_capture_if.sv
// Audio front-end and CPU FIFO signals of the capture block.
interface pcm_capture_if;
    logic        next_sample;
    logic [15:0] left_in;
    logic [15:0] right_in;
    logic [7:0]  sample_rate;
    logic        mode_stereo;
    logic        mode_16bit;
    logic        fifo_reset;
    logic        fifo_read;
    logic [7:0]  fifo_rddata;
    logic        fifo_empty;
    logic        fifo_almost_full;
    logic        fifo_full;
    logic        overrun;

    modport master (
        output next_sample, left_in, right_in, sample_rate, mode_stereo, mode_16bit,
               fifo_reset, fifo_read,
        input  fifo_rddata, fifo_empty, fifo_almost_full, fifo_full, overrun
    );

    modport slave (
        input  next_sample, left_in, right_in, sample_rate, mode_stereo, mode_16bit,
               fifo_reset, fifo_read,
        output fifo_rddata, fifo_empty, fifo_almost_full, fifo_full, overrun
    );
endinterface

// File: rtl/pcm_capture_fifo.sv
// Capture byte FIFO: single clock, first-word-fall-through registered head,
// synchronous flush. Mirror image of the playback audio FIFO.
module pcm_capture_fifo #(
    parameter int DEPTH   = 4096,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               wr_en_i,
    input  logic [7:0]         wr_data_i,
    input  logic               rd_en_i,
    output logic [7:0]         rd_data_o,
    output logic [LEVEL_W-1:0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]         mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q, rd_next;
    logic [LEVEL_W-1:0] level_q;
    logic [7:0]         rd_data_q;
    logic               do_wr, do_rd;

    assign do_wr   = wr_en_i && !flush_i && (level_q != LEVEL_W'(DEPTH));
    assign do_rd   = rd_en_i && !flush_i && (level_q != '0);
    assign rd_next = rd_ptr_q + AW'(1);

    // NOTE: storage has no reset; contents are only observable through the pointers.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

    // NOTE: sequential state uses <= so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_rd) rd_ptr_q <= rd_next;
            case ({do_wr, do_rd})
                2'b10:   level_q <= level_q + LEVEL_W'(1);
                2'b01:   level_q <= level_q - LEVEL_W'(1);
                default: level_q <= level_q;
            endcase
            // With one byte left the new head is the byte being written right now.
            if (do_rd)
                rd_data_q <= (level_q == LEVEL_W'(1)) ? wr_data_i : mem_q[rd_next];
            else if (do_wr && level_q == '0)
                rd_data_q <= wr_data_i;
        end
    end

    assign rd_data_o = rd_data_q;
    assign level_o   = level_q;
endmodule

// File: rtl/pcm_capture.sv
// PCM record path: decimates front-end samples with the shared rate
// accumulator, packs whole frames into bytes and queues them for the CPU.
module pcm_capture #(
    parameter int FIFO_DEPTH = 4096,
    parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    pcm_capture_if.slave  bus
);
    import pcm_capture_pkg::*;

    pcm_state_e         state_q, state_d;
    logic [7:0]         acc_q, acc_d, rate_inc;
    logic               cap_tick_q;
    logic [15:0]        l_in_q, r_in_q, frame_l_q, frame_r_q;
    logic               frame_stereo_q, frame_16_q, overrun_q;
    logic               tick_live, admit, drop, wr_en;
    logic [7:0]         wr_byte;
    logic [LEVEL_W-1:0] fifo_level, free_bytes;

    assign rate_inc = (bus.sample_rate > MAX_RATE) ? MAX_RATE : bus.sample_rate;
    assign acc_d    = acc_q + rate_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            cap_tick_q <= 1'b0;
            l_in_q     <= '0;
            r_in_q     <= '0;
        end else if (bus.next_sample) begin
            acc_q      <= acc_d;
            cap_tick_q <= acc_d[7] ^ acc_q[7];
            l_in_q     <= bus.left_in;
            r_in_q     <= bus.right_in;
        end else begin
            cap_tick_q <= 1'b0;
        end
    end

    // Only whole frames are admitted so L/R and byte order never slip.
    assign free_bytes = LEVEL_W'(FIFO_DEPTH) - fifo_level;
    assign tick_live  = cap_tick_q && !bus.fifo_reset;
    assign admit      = tick_live && (state_q == ST_IDLE) &&
                        (free_bytes >= LEVEL_W'(frame_bytes(bus.mode_stereo, bus.mode_16bit)));
    assign drop       = tick_live && !admit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            frame_l_q      <= '0;
            frame_r_q      <= '0;
            frame_stereo_q <= 1'b0;
            frame_16_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (admit) begin
                frame_l_q      <= bus.mode_stereo ? l_in_q : mono_mix(l_in_q, r_in_q);
                frame_r_q      <= r_in_q;
                frame_stereo_q <= bus.mode_stereo;
                frame_16_q     <= bus.mode_16bit;
            end
            if (bus.fifo_reset) overrun_q <= 1'b0;
            else if (drop)      overrun_q <= 1'b1;
        end
    end

    // NOTE: defaults first so no path through the case can infer a latch.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_byte = '0;
        case (state_q)
            ST_IDLE: if (admit) state_d = ST_WR_L_LO;
            ST_WR_L_LO: begin
                wr_en   = 1'b1;
                wr_byte = frame_16_q ? frame_l_q[7:0] : frame_l_q[15:8];
                state_d = frame_16_q ? ST_WR_L_HI : (frame_stereo_q ? ST_WR_R_LO : ST_IDLE);
            end
            ST_WR_L_HI: begin
                wr_en   = 1'b1;
                wr_byte = frame_l_q[15:8];
                state_d = frame_stereo_q ? ST_WR_R_LO : ST_IDLE;
            end
            ST_WR_R_LO: begin
                wr_en   = 1'b1;
                wr_byte = frame_16_q ? frame_r_q[7:0] : frame_r_q[15:8];
                state_d = frame_16_q ? ST_WR_R_HI : ST_IDLE;
            end
            ST_WR_R_HI: begin
                wr_en   = 1'b1;
                wr_byte = frame_r_q[15:8];
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.fifo_reset) begin
            state_d = ST_IDLE;
            wr_en   = 1'b0;
        end
    end

    pcm_capture_fifo #(.DEPTH(FIFO_DEPTH), .LEVEL_W(LEVEL_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (bus.fifo_reset),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_byte),
        .rd_en_i   (bus.fifo_read),
        .rd_data_o (bus.fifo_rddata),
        .level_o   (fifo_level)
    );

    assign bus.fifo_empty       = (fifo_level == '0);
    assign bus.fifo_almost_full = (fifo_level >= LEVEL_W'(FIFO_DEPTH * 3 / 4));
    assign bus.fifo_full        = (fifo_level == LEVEL_W'(FIFO_DEPTH));
    assign bus.overrun          = overrun_q;
endmodule

// File: tb/tb_pcm_capture.sv
// Directed bench for pcm_capture with a 16-byte FIFO so the fill and
// overrun boundaries are reachable in a few hundred cycles.
module tb_pcm_capture;
    import pcm_capture_pkg::*;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    pcm_capture_if bus();

    pcm_capture #(.FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mode(input logic [7:0] rate, input logic stereo, input logic b16);
        bus.sample_rate = rate;
        bus.mode_stereo = stereo;
        bus.mode_16bit  = b16;
    endtask

    task automatic send_tick(input logic [15:0] l, input logic [15:0] r);
        bus.left_in     = l;
        bus.right_in    = r;
        bus.next_sample = 1'b1;
        step();
        bus.next_sample = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
        send_tick(l, r);
        step(5);
    endtask

    task automatic pop_byte(output logic [7:0] b);
        b = bus.fifo_rddata;
        bus.fifo_read = 1'b1;
        step();
        bus.fifo_read = 1'b0;
    endtask

    task automatic test_reset();
        step(2);
        n_cmp++; if (bus.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", bus.fifo_empty); end
        n_cmp++; if (bus.fifo_full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", bus.fifo_full); end
        n_cmp++; if (bus.fifo_almost_full !== 1'b0) begin n_bad++; $display("FAIL rst_afull: got %b want 0", bus.fifo_almost_full); end
        n_cmp++; if (bus.fifo_rddata !== 8'h00) begin n_bad++; $display("FAIL rst_rddata: got %h want 00", bus.fifo_rddata); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b want 0", bus.overrun); end
        rst = 1'b0;
        step();
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_bad++; $display("FAIL rst_state: got %0d want IDLE", dut.state_q); end
    endtask

    task automatic test_stereo16();
        logic [7:0] exp [4] = '{8'h34, 8'h12, 8'hCD, 8'hAB};
        logic [7:0] got;
        set_mode(8'd128, 1'b1, 1'b1);
        send_tick(16'h1234, 16'hABCD);
        step();
        n_cmp++; if (bus.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL s16_empty_n2: got %b want 1", bus.fifo_empty); end
        step();
        n_cmp++; if (bus.fifo_empty !== 1'b0) begin n_bad++; $display("FAIL s16_empty_n3: got %b want 0", bus.fifo_empty); end
        step(3);
        n_cmp++; if (dut.fifo_level !== 5'd4) begin n_bad++; $display("FAIL s16_level: got %0d want 4", dut.fifo_level); end
        for (int i = 0; i < 4; i++) begin
            pop_byte(got);
            n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL s16_byte%0d: got %h want %h", i, got, exp[i]); end
        end
        n_cmp++; if (bus.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL s16_drained: got %b want 1", bus.fifo_empty); end
    endtask

    task automatic test_decimation();
        logic [7:0] got;
        set_mode(8'd32, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            send_frame(16'h4000, 16'h4000);
            n_cmp++;
            if (dut.fifo_level !== 5'((i + 1) / 4)) begin
                n_bad++; $display("FAIL dec_level_tick%0d: got %0d want %0d", i, dut.fifo_level, (i + 1) / 4);
            end
        end
        for (int i = 0; i < 4; i++) begin
            pop_byte(got);
            n_cmp++; if (got !== 8'h40) begin n_bad++; $display("FAIL dec_byte%0d: got %h want 40", i, got); end
        end
        n_cmp++; if (bus.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL dec_drained: got %b want 1", bus.fifo_empty); end
    endtask

    task automatic test_mono16();
        logic [7:0] exp [6] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'hFF, 8'h7F};
        logic [7:0] got;
        set_mode(8'd200, 1'b0, 1'b1);
        send_frame(16'h8000, 16'h8000);
        send_frame(16'h7FFF, 16'h8001);
        send_frame(16'h7FFF, 16'h7FFF);
        n_cmp++; if (dut.fifo_level !== 5'd6) begin n_bad++; $display("FAIL m16_level: got %0d want 6", dut.fifo_level); end
        for (int i = 0; i < 6; i++) begin
            pop_byte(got);
            n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL m16_byte%0d: got %h want %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] got;
        set_mode(8'd128, 1'b1, 1'b1);
        send_frame(16'h1100, 16'h2200);
        send_frame(16'h3300, 16'h4400);
        send_frame(16'h5500, 16'h6600);
        set_mode(8'd128, 1'b0, 1'b0);
        send_frame(16'h7700, 16'h7700);
        n_cmp++; if (dut.fifo_level !== 5'd13) begin n_bad++; $display("FAIL ovr_fill: got %0d want 13", dut.fifo_level); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_pre: got %b want 0", bus.overrun); end
        set_mode(8'd128, 1'b1, 1'b1);
        send_frame(16'h1234, 16'h5678);
        n_cmp++; if (dut.fifo_level !== 5'd13) begin n_bad++; $display("FAIL ovr_level: got %0d want 13", dut.fifo_level); end
        n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_flag: got %b want 1", bus.overrun); end
        n_cmp++; if (bus.fifo_almost_full !== 1'b1) begin n_bad++; $display("FAIL ovr_afull: got %b want 1", bus.fifo_almost_full); end
        pop_byte(got);
        n_cmp++; if (got !== 8'h00) begin n_bad++; $display("FAIL ovr_pop: got %h want 00", got); end
        set_mode(8'd128, 1'b1, 1'b0);
        send_frame(16'h8811, 16'h9922);
        n_cmp++; if (dut.fifo_level !== 5'd14) begin n_bad++; $display("FAIL s8_level: got %0d want 14", dut.fifo_level); end
        n_cmp++; if (bus.fifo_full !== 1'b0) begin n_bad++; $display("FAIL s8_notfull: got %b want 0", bus.fifo_full); end
        send_frame(16'hAA00, 16'hBB00);
        n_cmp++; if (bus.fifo_full !== 1'b1) begin n_bad++; $display("FAIL s8_full: got %b want 1", bus.fifo_full); end
        set_mode(8'd128, 1'b0, 1'b0);
        send_frame(16'h0101, 16'h0101);
        n_cmp++; if (dut.fifo_level !== 5'd16) begin n_bad++; $display("FAIL full_drop: got %0d want 16", dut.fifo_level); end
    endtask

    task automatic test_fifo_reset();
        logic [7:0] exp_old [4] = '{8'h11, 8'h00, 8'h22, 8'h00};
        logic [7:0] exp_new [4] = '{8'h66, 8'h55, 8'h88, 8'h77};
        logic [7:0] got;
        for (int i = 0; i < 4; i++) begin
            pop_byte(got);
            n_cmp++; if (got !== exp_old[i]) begin n_bad++; $display("FAIL frst_old%0d: got %h want %h", i, got, exp_old[i]); end
        end
        set_mode(8'd128, 1'b1, 1'b1);
        send_tick(16'hCAFE, 16'hBEEF);
        step(2);
        n_cmp++; if (dut.state_q !== ST_WR_L_HI) begin n_bad++; $display("FAIL frst_mid_state: got %0d want WR_L_HI", dut.state_q); end
        n_cmp++; if (dut.fifo_level !== 5'd13) begin n_bad++; $display("FAIL frst_mid_level: got %0d want 13", dut.fifo_level); end
        bus.fifo_reset = 1'b1;
        step();
        bus.fifo_reset = 1'b0;
        n_cmp++; if (bus.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL frst_empty: got %b want 1", bus.fifo_empty); end
        n_cmp++; if (dut.fifo_level !== 5'd0) begin n_bad++; $display("FAIL frst_level: got %0d want 0", dut.fifo_level); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL frst_overrun: got %b want 0", bus.overrun); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_bad++; $display("FAIL frst_state: got %0d want IDLE", dut.state_q); end
        step(4);
        n_cmp++; if (bus.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL frst_abandoned: got %b want 1", bus.fifo_empty); end
        send_frame(16'h5566, 16'h7788);
        for (int i = 0; i < 4; i++) begin
            pop_byte(got);
            n_cmp++; if (got !== exp_new[i]) begin n_bad++; $display("FAIL frst_new%0d: got %h want %h", i, got, exp_new[i]); end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] exp [4] = '{8'hCD, 8'hAB, 8'h34, 8'h12};
        logic [7:0] got;
        set_mode(8'd128, 1'b1, 1'b1);
        send_tick(16'h1357, 16'h2468);
        send_tick(16'h1357, 16'h2468);
        step();
        #2;
        n_cmp++; if (bus.overrun !== 1'b1) begin n_bad++; $display("FAIL busy_drop: got %b want 1", bus.overrun); end
        n_cmp++; if (bus.fifo_rddata !== 8'h57) begin n_bad++; $display("FAIL arst_pre_rd: got %h want 57", bus.fifo_rddata); end
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.fifo_empty !== 1'b1) begin n_bad++; $display("FAIL arst_empty: got %b want 1", bus.fifo_empty); end
        n_cmp++; if (bus.fifo_rddata !== 8'h00) begin n_bad++; $display("FAIL arst_rddata: got %h want 00", bus.fifo_rddata); end
        n_cmp++; if (bus.overrun !== 1'b0) begin n_bad++; $display("FAIL arst_overrun: got %b want 0", bus.overrun); end
        n_cmp++; if (dut.state_q !== ST_IDLE) begin n_bad++; $display("FAIL arst_state: got %0d want IDLE", dut.state_q); end
        step();
        rst = 1'b0;
        step();
        send_frame(16'hABCD, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            pop_byte(got);
            n_cmp++; if (got !== exp[i]) begin n_bad++; $display("FAIL arst_after%0d: got %h want %h", i, got, exp[i]); end
        end
    endtask

    initial begin
        bus.next_sample = 1'b0;
        bus.left_in     = '0;
        bus.right_in    = '0;
        bus.sample_rate = '0;
        bus.mode_stereo = 1'b0;
        bus.mode_16bit  = 1'b0;
        bus.fifo_reset  = 1'b0;
        bus.fifo_read   = 1'b0;
        test_reset();
        test_stereo16();
        test_decimation();
        test_mono16();
        test_overrun();
        test_fifo_reset();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pcm_capture.md
Name: pcm_capture

Overview:
- Record-direction counterpart of the PCM playback path.
- Takes signed 16-bit left/right samples from the audio input front-end (ADC/I2S receiver) on the shared sample tick and decimates them with the same 8-bit rate accumulator as playback.
- Packs each captured frame into bytes (8/16-bit, mono/stereo) and writes them into an internal byte FIFO.
- The CPU register interface drains that FIFO.

Parameters:
FIFO_DEPTH, 4096, FIFO capacity in bytes (power of two).
LEVEL_W, $clog2(FIFO_DEPTH)+1, width of the internal occupancy counter.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
next_sample  input  1  one-cycle tick at the base audio rate, shared with playback
left_in  input  16  signed left sample, valid when next_sample=1
right_in  input  16  signed right sample, valid when next_sample=1
sample_rate  input  8  accumulator increment; values >128 are treated as 128
mode_stereo  input  1  1=write L and R, 0=write mono mix
mode_16bit  input  1  1=16-bit little-endian bytes, 0=signed upper byte only
fifo_reset  input  1  synchronous FIFO flush, one cycle
fifo_read  input  1  CPU pops one byte
fifo_rddata  output  8  byte at FIFO head, valid while !fifo_empty
fifo_empty  output  1  FIFO holds no bytes
fifo_almost_full  output  1  level >= FIFO_DEPTH*3/4
fifo_full  output  1  level == FIFO_DEPTH
overrun  output  1  sticky: at least one frame dropped since the last fifo_reset

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock.
- Reset state:
  - state=IDLE, accumulator=0, level=0, overrun=0.
  - fifo_empty=1, fifo_full=0, fifo_almost_full=0, fifo_rddata=0.
- Rate accumulator:
  - On next_sample: acc <= acc + min(sample_rate,128) (8-bit, wraps), and acc[7] is saved.
  - The cycle after next_sample, capture_tick=1 iff acc[7] toggled.
  - sample_rate=128 captures every tick; sample_rate=0 never captures.
- Latching:
  - On next_sample, left_in/right_in are registered unconditionally.
  - On capture_tick, the registered pair is copied into the frame holding registers.
  - Mono value = (L+R)>>>1, computed as a 17-bit signed sum then arithmetic shift (e.g. 0x7FFF+0x7FFF -> 0x7FFF; 0x8000+0x8000 -> 0x8000).
- Frame size (bytes): mono8=1, stereo8=2, mono16=2, stereo16=4.
- Admission check on capture_tick in IDLE:
  - If FIFO_DEPTH-level >= frame size, go to the first WR state.
  - Otherwise drop the frame, set overrun, stay IDLE.
  - Frames are never partially written, so L/R and byte alignment is preserved.
- States: IDLE, WR_L_LO, WR_L_HI, WR_R_LO, WR_R_HI.
  - Each WR state writes exactly one byte in that cycle.
  - WR_L_LO: writes L[7:0] in 16-bit mode, L[15:8] in 8-bit mode.
  - Sequence 16-bit: L_LO, L_HI, then R_LO, R_HI if stereo, then IDLE.
  - Sequence 8-bit: L_LO, then R_LO (writes R[15:8]) if stereo, then IDLE.
  - In mono, "L" means the mono mix.
- Latency: next_sample at cycle N -> capture_tick at N+1 -> first byte written at N+2, remaining bytes on consecutive cycles.
- A stereo16 frame occupies the FIFO by N+5 (fifo_empty falls at N+3).
- capture_tick while not IDLE: that frame is dropped and overrun is set (base rate makes this unreachable in normal use).
- Mode changes take effect at the next admission; a frame in flight uses the modes latched at its capture_tick.
- Level counter:
  - Increments on a write, decrements on a read with !fifo_empty.
  - A simultaneous write and read leaves it unchanged.
  - fifo_read while empty is ignored (no pointer move, no underflow).
- fifo_full/fifo_almost_full/fifo_empty are derived combinationally from level.
- fifo_rddata is registered with first-word-fall-through semantics; it updates the cycle after a pop or after the first write into an empty FIFO.
- fifo_reset:
  - Same cycle effect: pointers and level cleared, overrun cleared, state forced to IDLE (in-flight frame abandoned).
  - The accumulator is not touched.
  - A capture_tick coincident with fifo_reset is discarded.

Decomposition:
- Shared audio package:
  - state encoding constants (IDLE/WR_*)
  - frame-size constants
  - MAX_RATE=128
  - mono-mix function
  - volume log table (so playback and capture use the same definitions)
- One sub-module: capture_fifo.
  - Single-clock byte FIFO: FIFO_DEPTH entries, wr_en/rd_en, level output, first-word-fall-through read, flush input.
  - Structurally mirrors the playback audio FIFO with read and write roles swapped.

Test Plan:
- sample_rate=128, stereo16, L=0x1234 R=0xABCD, one next_sample -> bytes 34,12,CD,AB readable in order; fifo_empty falls exactly 3 cycles after next_sample.
- sample_rate=32, mono8, 16 ticks, L=R=0x4000 -> exactly 4 bytes, each 0x40; no write on the other 12 ticks.
- mono16 with L=0x8000 R=0x8000, then L=0x7FFF R=0x8001 -> bytes 00,80 then 00,00.
- Fill FIFO to FIFO_DEPTH-3, stereo16 tick -> no bytes written, level unchanged, overrun=1.
- Pop one byte, then stereo8 tick -> 2 bytes written; fifo_full=1 only if the level reaches FIFO_DEPTH.
- fifo_reset asserted during WR_L_HI of a stereo16 frame -> fifo_empty=1, level=0, overrun=0, state IDLE; the next tick captures a full frame normally.
- Async rst mid-frame -> all outputs at reset values immediately, without waiting for a clk edge.
